// File: rtl/csr_defs.sv
// Shared definitions for the machine-mode CSR unit: address map, op encodings,
// mstatus field positions and write masks.
package csr_defs;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // Only MIE and MPIE are stored; MPP is a constant 2'b11 (M-mode only core).
  localparam logic [31:0] MSTATUS_WMASK    = 32'h0000_0088;
  localparam logic [31:0] MSTATUS_MPP_BITS = 32'h0000_1800;
  localparam logic [31:0] MTVEC_WMASK      = 32'hFFFF_FFFC;
  localparam logic [31:0] MEPC_WMASK       = 32'hFFFF_FFFE;

  function automatic logic csr_is_mapped(input logic [11:0] idx);
    logic hit;
    hit = 1'b0;
    case (idx)
      CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
      CSR_MCYCLE, CSR_MCYCLEH, CSR_CYCLE, CSR_CYCLEH, CSR_MHARTID: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic logic csr_is_read_only(input logic [11:0] idx);
    logic ro;
    ro = 1'b0;
    case (idx)
      CSR_CYCLE, CSR_CYCLEH, CSR_MHARTID: ro = 1'b1;
      default: ro = 1'b0;
    endcase
    return ro;
  endfunction

endpackage

// File: rtl/csr_mcycle_counter.sv
// Free-running 64-bit cycle counter built from two halves, each independently loadable.
module csr_mcycle_counter #(
  parameter int HALF = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ld_lo,
  input  logic            ld_hi,
  input  logic [HALF-1:0] ld_dat,
  output logic [HALF-1:0] lo,
  output logic [HALF-1:0] hi
);

  logic [HALF-1:0] lo_q, hi_q, lo_nxt, hi_nxt;
  logic            carry;

  // A loaded half takes the written value; the other half keeps counting, and
  // the high half still sees the carry generated by the old low value.
  always_comb begin
    carry  = &lo_q;
    lo_nxt = ld_lo ? ld_dat : lo_q + HALF'(1);
    hi_nxt = ld_hi ? ld_dat : hi_q + HALF'(carry);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      lo_q <= lo_nxt;
      hi_q <= hi_nxt;
    end
  end

  assign lo = lo_q;
  assign hi = hi_q;

endmodule

// File: rtl/dfflr.sv
// Reset flop with load enable; the building block for every plain CSR register.
module dfflr #(
  parameter int             W         = 32,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   q <= RESET_VAL;
    else if (ld) q <= d;
  end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR responder: CSR read/modify/write, trap entry, mret and mcycle.
module csr_unit
  import csr_defs::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0004,
  parameter int              HARTID      = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            csr_valid,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_idx,
  input  logic [XLEN-1:0] csr_write_dat,
  input  logic            csr_src_is_zero,
  output logic [XLEN-1:0] csr_read_dat,
  output logic            csr_illegal,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_cause,
  input  logic            mret_valid,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] mepc_out,
  output logic            mie_out
);

  localparam logic [XLEN-1:0] MSTATUS_MASK = XLEN'(MSTATUS_WMASK);
  localparam logic [XLEN-1:0] MPP_BITS     = XLEN'(MSTATUS_MPP_BITS);
  localparam logic [XLEN-1:0] MTVEC_MASK   = XLEN'(MTVEC_WMASK);
  localparam logic [XLEN-1:0] MEPC_MASK    = XLEN'(MEPC_WMASK);

  csr_op_e op;
  logic    mapped, read_only, src_writes, illegal, csr_we, mret_take;
  logic    we_mstatus, we_mtvec, we_mscratch, we_mepc, we_mcause, we_mcycle, we_mcycleh;

  logic [XLEN-1:0] old_val, new_val;
  logic [XLEN-1:0] mstatus_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [XLEN-1:0] mstatus_d, mepc_d, mcause_d;
  logic            mstatus_ld, mepc_ld, mcause_ld;
  logic [XLEN-1:0] mcycle_lo, mcycle_hi;

  assign op = csr_op_e'(csr_op);

  // Read mux reflects the register state before any update this cycle.
  always_comb begin
    old_val = '0;
    case (csr_idx)
      CSR_MSTATUS:            old_val = mstatus_q | MPP_BITS;
      CSR_MTVEC:              old_val = mtvec_q;
      CSR_MSCRATCH:           old_val = mscratch_q;
      CSR_MEPC:               old_val = mepc_q;
      CSR_MCAUSE:             old_val = mcause_q;
      CSR_MCYCLE, CSR_CYCLE:  old_val = mcycle_lo;
      CSR_MCYCLEH, CSR_CYCLEH: old_val = mcycle_hi;
      CSR_MHARTID:            old_val = XLEN'(HARTID);
      default:                old_val = '0;
    endcase
  end

  // RS/RC with a zero source are pure reads and may target read-only CSRs.
  always_comb begin
    mapped     = csr_is_mapped(csr_idx);
    read_only  = csr_is_read_only(csr_idx);
    src_writes = (op != CSR_OP_NONE) && !((op != CSR_OP_RW) && csr_src_is_zero);
    illegal    = csr_valid && (!mapped || (read_only && src_writes));
    csr_we     = csr_valid && src_writes && !illegal && !trap_valid;
    mret_take  = mret_valid && !trap_valid;
  end

  always_comb begin
    new_val = old_val;
    case (op)
      CSR_OP_RW: new_val = csr_write_dat;
      CSR_OP_RS: new_val = old_val | csr_write_dat;
      CSR_OP_RC: new_val = old_val & ~csr_write_dat;
      default:   new_val = old_val;
    endcase
  end

  always_comb begin
    we_mstatus  = csr_we && (csr_idx == CSR_MSTATUS);
    we_mtvec    = csr_we && (csr_idx == CSR_MTVEC);
    we_mscratch = csr_we && (csr_idx == CSR_MSCRATCH);
    we_mepc     = csr_we && (csr_idx == CSR_MEPC);
    we_mcause   = csr_we && (csr_idx == CSR_MCAUSE);
    we_mcycle   = csr_we && (csr_idx == CSR_MCYCLE);
    we_mcycleh  = csr_we && (csr_idx == CSR_MCYCLEH);
  end

  // Priority: trap, then an explicit CSR write, then mret stacking.
  always_comb begin
    mstatus_d  = mstatus_q;
    mstatus_ld = 1'b0;
    if (trap_valid) begin
      mstatus_d[MSTATUS_MPIE] = mstatus_q[MSTATUS_MIE];
      mstatus_d[MSTATUS_MIE]  = 1'b0;
      mstatus_ld              = 1'b1;
    end else if (we_mstatus) begin
      mstatus_d  = new_val & MSTATUS_MASK;
      mstatus_ld = 1'b1;
    end else if (mret_take) begin
      mstatus_d[MSTATUS_MIE]  = mstatus_q[MSTATUS_MPIE];
      mstatus_d[MSTATUS_MPIE] = 1'b1;
      mstatus_ld              = 1'b1;
    end
  end

  always_comb begin
    mepc_d    = (trap_valid ? trap_pc : new_val) & MEPC_MASK;
    mepc_ld   = trap_valid || we_mepc;
    mcause_d  = trap_valid ? trap_cause : new_val;
    mcause_ld = trap_valid || we_mcause;
  end

  dfflr #(.W(XLEN), .RESET_VAL('0)) mstatus_dfflr (
    .clk(clk), .reset(reset), .ld(mstatus_ld), .d(mstatus_d), .q(mstatus_q)
  );

  dfflr #(.W(XLEN), .RESET_VAL(MTVEC_RESET)) mtvec_dfflr (
    .clk(clk), .reset(reset), .ld(we_mtvec), .d(new_val & MTVEC_MASK), .q(mtvec_q)
  );

  dfflr #(.W(XLEN), .RESET_VAL('0)) mscratch_dfflr (
    .clk(clk), .reset(reset), .ld(we_mscratch), .d(new_val), .q(mscratch_q)
  );

  dfflr #(.W(XLEN), .RESET_VAL('0)) epc_dfflr (
    .clk(clk), .reset(reset), .ld(mepc_ld), .d(mepc_d), .q(mepc_q)
  );

  dfflr #(.W(XLEN), .RESET_VAL('0)) mcause_dfflr (
    .clk(clk), .reset(reset), .ld(mcause_ld), .d(mcause_d), .q(mcause_q)
  );

  csr_mcycle_counter #(.HALF(XLEN)) mcycle_counter (
    .clk    (clk),
    .reset  (reset),
    .ld_lo  (we_mcycle),
    .ld_hi  (we_mcycleh),
    .ld_dat (new_val),
    .lo     (mcycle_lo),
    .hi     (mcycle_hi)
  );

  // Redirect is gated by reset so it drops the instant reset asserts.
  always_comb begin
    csr_read_dat   = old_val;
    csr_illegal    = illegal;
    redirect_valid = !reset && (trap_valid || mret_valid);
    redirect_pc    = trap_valid ? {mtvec_q[XLEN-1:2], 2'b00} : mepc_q;
    mepc_out       = mepc_q;
    mie_out        = mstatus_q[MSTATUS_MIE];
  end

endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit: reset, CSR RMW, trap/mret, collisions,
// illegal accesses and the 64-bit cycle counter.
module tb_csr_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        csr_valid;
  logic [1:0]  csr_op;
  logic [11:0] csr_idx;
  logic [31:0] csr_write_dat;
  logic        csr_src_is_zero;
  logic [31:0] csr_read_dat;
  logic        csr_illegal;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic [31:0] trap_cause;
  logic        mret_valid;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] mepc_out;
  logic        mie_out;

  int tests_run    = 0;
  int tests_failed = 0;

  csr_unit #(.XLEN(32), .MTVEC_RESET(32'h0000_0004), .HARTID(0)) dut (
    .clk(clk), .reset(reset),
    .csr_valid(csr_valid), .csr_op(csr_op), .csr_idx(csr_idx),
    .csr_write_dat(csr_write_dat), .csr_src_is_zero(csr_src_is_zero),
    .csr_read_dat(csr_read_dat), .csr_illegal(csr_illegal),
    .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_cause(trap_cause),
    .mret_valid(mret_valid), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .mepc_out(mepc_out), .mie_out(mie_out)
  );

  always #5 clk = ~clk;

  task automatic drive_idle();
    csr_valid = 1'b0; csr_op = 2'b00; csr_idx = 12'h000; csr_write_dat = '0;
    csr_src_is_zero = 1'b0; trap_valid = 1'b0; trap_pc = '0; trap_cause = '0;
    mret_valid = 1'b0;
  endtask

  task automatic csr_cmd(input logic [1:0] op, input logic [11:0] idx,
                         input logic [31:0] dat, input logic src_zero);
    csr_valid = 1'b1; csr_op = op; csr_idx = idx; csr_write_dat = dat;
    csr_src_is_zero = src_zero;
  endtask

  task automatic read_csr(input logic [11:0] idx, output logic [31:0] val);
    csr_valid = 1'b0; csr_op = 2'b00; csr_idx = idx;
    #1 val = csr_read_dat;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  task automatic test_reset();
    logic [31:0] v;
    drive_idle();
    reset = 1'b1;
    #2;
    tests_run++;
    if (mepc_out !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_mepc: got %h expected %h", mepc_out, 32'h0); end
    tests_run++;
    if (mie_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mie: got %b expected 0", mie_out); end
    tests_run++;
    if (redirect_valid !== 1'b0 || csr_illegal !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset_outputs: redirect=%b illegal=%b expected 0 0", redirect_valid, csr_illegal);
    end
    read_csr(12'h305, v);
    tests_run++;
    if (v !== 32'h0000_0004) begin tests_failed++; $display("[TB] FAIL reset_mtvec: got %h expected %h", v, 32'h4); end
    read_csr(12'h300, v);
    tests_run++;
    if (v !== 32'h0000_1800) begin tests_failed++; $display("[TB] FAIL reset_mstatus: got %h expected %h", v, 32'h1800); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    read_csr(12'hB00, v);
    tests_run++;
    if (v !== 32'd0) begin tests_failed++; $display("[TB] FAIL mcycle_start0: got %0d expected 0", v); end
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1 read_csr(12'hB00, v);
      tests_run++;
      if (v !== 32'(i)) begin tests_failed++; $display("[TB] FAIL mcycle_count: got %0d expected %0d", v, i); end
    end
  endtask

  task automatic test_mepc();
    logic [31:0] v;
    @(negedge clk);
    csr_cmd(2'b01, 12'h341, 32'hFFFF_FFFF, 1'b0);
    #1;
    tests_run++;
    if (csr_read_dat !== 32'h0 || csr_illegal !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL mepc_rw_old: got %h illegal=%b expected 00000000 0", csr_read_dat, csr_illegal);
    end
    step();
    tests_run++;
    if (mepc_out !== 32'hFFFF_FFFE) begin tests_failed++; $display("[TB] FAIL mepc_rw: got %h expected %h", mepc_out, 32'hFFFF_FFFE); end
    @(negedge clk);
    csr_cmd(2'b11, 12'h341, 32'h0000_0011, 1'b0);
    #1;
    tests_run++;
    if (csr_read_dat !== 32'hFFFF_FFFE) begin tests_failed++; $display("[TB] FAIL mepc_rc_old: got %h expected %h", csr_read_dat, 32'hFFFF_FFFE); end
    step();
    tests_run++;
    if (mepc_out !== 32'hFFFF_FFEE) begin tests_failed++; $display("[TB] FAIL mepc_rc: got %h expected %h", mepc_out, 32'hFFFF_FFEE); end
    // Non-zero data with the zero flag set: the flag alone must suppress the write.
    @(negedge clk);
    csr_cmd(2'b10, 12'h341, 32'h0000_0101, 1'b1);
    step();
    tests_run++;
    if (mepc_out !== 32'hFFFF_FFEE) begin tests_failed++; $display("[TB] FAIL mepc_rs_zero: got %h expected %h", mepc_out, 32'hFFFF_FFEE); end
    read_csr(12'h341, v);
    tests_run++;
    if (v !== 32'hFFFF_FFEE) begin tests_failed++; $display("[TB] FAIL mepc_read: got %h expected %h", v, 32'hFFFF_FFEE); end
  endtask

  task automatic test_trap_mret();
    logic [31:0] v;
    @(negedge clk);
    csr_cmd(2'b10, 12'h300, 32'h0000_0008, 1'b0);
    step();
    tests_run++;
    if (mie_out !== 1'b1) begin tests_failed++; $display("[TB] FAIL mie_set: got %b expected 1", mie_out); end
    @(negedge clk);
    trap_valid = 1'b1; trap_pc = 32'h0000_0031; trap_cause = 32'h0000_000B;
    #1;
    tests_run++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_0004) begin
      tests_failed++; $display("[TB] FAIL trap_redirect: got %b/%h expected 1/00000004", redirect_valid, redirect_pc);
    end
    step();
    tests_run++;
    if (mepc_out !== 32'h0000_0030) begin tests_failed++; $display("[TB] FAIL trap_mepc: got %h expected %h", mepc_out, 32'h30); end
    read_csr(12'h342, v);
    tests_run++;
    if (v !== 32'h0000_000B) begin tests_failed++; $display("[TB] FAIL trap_mcause: got %h expected %h", v, 32'hB); end
    read_csr(12'h300, v);
    tests_run++;
    if (v !== 32'h0000_1880 || mie_out !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL trap_mstatus: got %h mie=%b expected 00001880 0", v, mie_out);
    end
    @(negedge clk);
    mret_valid = 1'b1;
    #1;
    tests_run++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_0030) begin
      tests_failed++; $display("[TB] FAIL mret_redirect: got %b/%h expected 1/00000030", redirect_valid, redirect_pc);
    end
    step();
    read_csr(12'h300, v);
    tests_run++;
    if (v !== 32'h0000_1888 || mie_out !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL mret_mstatus: got %h mie=%b expected 00001888 1", v, mie_out);
    end
  endtask

  task automatic test_collision();
    logic [31:0] v;
    @(negedge clk);
    csr_cmd(2'b01, 12'h340, 32'h1234_5678, 1'b0);
    trap_valid = 1'b1; trap_pc = 32'h0000_0100; trap_cause = 32'h0000_0002;
    #1;
    tests_run++;
    if (redirect_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL collide_redirect: got %b expected 1", redirect_valid); end
    step();
    read_csr(12'h340, v);
    tests_run++;
    if (v !== 32'h0) begin tests_failed++; $display("[TB] FAIL collide_mscratch: got %h expected %h", v, 32'h0); end
    tests_run++;
    if (mepc_out !== 32'h0000_0100 || mie_out !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL collide_trap: mepc=%h mie=%b expected 00000100 0", mepc_out, mie_out);
    end
    read_csr(12'h342, v);
    tests_run++;
    if (v !== 32'h0000_0002) begin tests_failed++; $display("[TB] FAIL collide_mcause: got %h expected %h", v, 32'h2); end
  endtask

  task automatic test_mtvec();
    logic [31:0] v;
    @(negedge clk);
    csr_cmd(2'b01, 12'h305, 32'h0000_1003, 1'b0);
    #1;
    tests_run++;
    if (csr_read_dat !== 32'h0000_0004) begin tests_failed++; $display("[TB] FAIL mtvec_old: got %h expected %h", csr_read_dat, 32'h4); end
    step();
    read_csr(12'h305, v);
    tests_run++;
    if (v !== 32'h0000_1000) begin tests_failed++; $display("[TB] FAIL mtvec_mask: got %h expected %h", v, 32'h1000); end
    @(negedge clk);
    trap_valid = 1'b1; trap_pc = 32'h0000_0200; trap_cause = 32'h0000_0003;
    #1;
    tests_run++;
    if (redirect_pc !== 32'h0000_1000) begin tests_failed++; $display("[TB] FAIL mtvec_redirect: got %h expected %h", redirect_pc, 32'h1000); end
    step();
  endtask

  task automatic test_illegal();
    logic [31:0] v;
    @(negedge clk);
    csr_cmd(2'b01, 12'hF14, 32'h0000_0005, 1'b0);
    #1;
    tests_run++;
    if (csr_illegal !== 1'b1) begin tests_failed++; $display("[TB] FAIL illegal_hartid_w: got %b expected 1", csr_illegal); end
    csr_cmd(2'b01, 12'h7C0, 32'h0000_0005, 1'b0);
    #1;
    tests_run++;
    if (csr_illegal !== 1'b1 || csr_read_dat !== 32'h0) begin
      tests_failed++; $display("[TB] FAIL illegal_unmapped: got %b/%h expected 1/00000000", csr_illegal, csr_read_dat);
    end
    csr_cmd(2'b01, 12'hC00, 32'h0000_0005, 1'b0);
    #1;
    tests_run++;
    if (csr_illegal !== 1'b1) begin tests_failed++; $display("[TB] FAIL illegal_cycle_w: got %b expected 1", csr_illegal); end
    step();
    tests_run++;
    if (mepc_out !== 32'h0000_0200) begin tests_failed++; $display("[TB] FAIL illegal_nochange: got %h expected %h", mepc_out, 32'h200); end
    @(negedge clk);
    csr_cmd(2'b10, 12'hF14, 32'h0, 1'b1);
    #1;
    tests_run++;
    if (csr_illegal !== 1'b0 || csr_read_dat !== 32'h0) begin
      tests_failed++; $display("[TB] FAIL hartid_read: got %b/%h expected 0/00000000", csr_illegal, csr_read_dat);
    end
    step();
  endtask

  task automatic test_counter();
    logic [31:0] lo, hi;
    @(negedge clk);
    csr_cmd(2'b01, 12'hB00, 32'hFFFF_FFFE, 1'b0);
    step();
    @(negedge clk);
    csr_cmd(2'b01, 12'hB80, 32'h0, 1'b0);
    step();
    read_csr(12'hB00, lo);
    read_csr(12'hB80, hi);
    tests_run++;
    if ({hi, lo} !== 64'h0000_0000_FFFF_FFFF) begin
      tests_failed++; $display("[TB] FAIL mcycle_load: got %h_%h expected 00000000_ffffffff", hi, lo);
    end
    @(posedge clk);
    #1 read_csr(12'hC00, lo);
    read_csr(12'hC80, hi);
    tests_run++;
    if ({hi, lo} !== 64'h0000_0001_0000_0000) begin
      tests_failed++; $display("[TB] FAIL mcycle_carry: got %h_%h expected 00000001_00000000", hi, lo);
    end
    @(posedge clk);
    #3 reset = 1'b1;
    mret_valid = 1'b1;
    csr_idx = 12'hB80;
    #1;
    tests_run++;
    if (csr_read_dat !== 32'h0 || mepc_out !== 32'h0 || redirect_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL async_reset: mcycleh=%h mepc=%h redirect=%b expected 0 0 0", csr_read_dat, mepc_out, redirect_valid);
    end
    drive_idle();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mepc();
    test_trap_mret();
    test_collision();
    test_mtvec();
    test_illegal();
    test_counter();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
